ray_dir_gen: RTL and testbench

RAY_DIR_GEN -- requirements
Module: ray_dir_gen

---
 rtl/ray_dir_gen_pkg.sv | 16 +
 rtl/ray_dir_gen_coord_fifo.sv | 79 +++++++
 rtl/ray_dir_gen.sv | 187 ++++++++++++++++++
 tb/tb_ray_dir_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ray_dir_gen_pkg.sv
// Shared types and default parameters for the ray direction generator.
// RayDirection is the packed direction word handed to the normalizer.
package ray_dir_gen_pkg;

    localparam int DIR_W        = 32;
    localparam int DEF_WIDTH    = 32;
    localparam int DEF_Q_BITS   = 16;
    localparam int DEF_TAG_SIZE = 4;

    typedef struct packed {
        logic [DIR_W-1:0] x;
        logic [DIR_W-1:0] y;
        logic [DIR_W-1:0] z;
    } RayDirection;

endpackage

// File: rtl/ray_dir_gen_coord_fifo.sv
// Coordinate FIFO: remembers the pixel of every ray in flight so returning
// results can be labelled. Head is visible combinationally (first-word fall-through).
module coord_fifo #(
    parameter int DEPTH = 4,
    parameter int X_W   = 2,
    parameter int Y_W   = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  logic [X_W-1:0] push_x,
    input  logic [Y_W-1:0] push_y,
    input  logic           pop,
    output logic [X_W-1:0] head_x,
    output logic [Y_W-1:0] head_y,
    output logic           empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [X_W-1:0] mem_x_q [DEPTH];
    logic [X_W-1:0] mem_x_d [DEPTH];
    logic [Y_W-1:0] mem_y_q [DEPTH];
    logic [Y_W-1:0] mem_y_d [DEPTH];
    logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           do_push_s, do_pop_s;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_x_d   = mem_x_q;
        mem_y_d   = mem_y_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        do_pop_s  = pop && (cnt_q != {CW{1'b0}});
        // A pop in the same cycle frees the slot, so a full FIFO may still accept.
        do_push_s = push && ((cnt_q != CNT_FULL) || do_pop_s);
        if (do_push_s) begin
            mem_x_d[wr_q] = push_x;
            mem_y_d[wr_q] = push_y;
            wr_d          = (wr_q == PTR_LAST) ? {PW{1'b0}} : wr_q + PW'(1);
        end else begin
            wr_d = wr_q;
        end
        if (do_pop_s) begin
            rd_d = (rd_q == PTR_LAST) ? {PW{1'b0}} : rd_q + PW'(1);
        end else begin
            rd_d = rd_q;
        end
        cnt_d = cnt_q + CW'(do_push_s) - CW'(do_pop_s);
    end

    // State registers with synchronous reset to empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_x_q[i] <= {X_W{1'b0}};
                mem_y_q[i] <= {Y_W{1'b0}};
            end
            wr_q  <= {PW{1'b0}};
            rd_q  <= {PW{1'b0}};
            cnt_q <= {CW{1'b0}};
        end else begin
            mem_x_q <= mem_x_d;
            mem_y_q <= mem_y_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign head_x = mem_x_q[rd_q];
    assign head_y = mem_y_q[rd_q];
    assign empty  = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/ray_dir_gen.sv
// Raster ray direction generator: issues one eye-space ray per pixel to a
// credit-limited normalizer and labels returning results with their pixel.
module ray_dir_gen
    import ray_dir_gen_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int Q_BITS   = DEF_Q_BITS,
    parameter int TAG_SIZE = DEF_TAG_SIZE,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int FOCAL    = 256
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_start,
    output logic                        norm_start,
    output RayDirection                 dir,
    input  logic                        norm_valid,
    output logic [$clog2(SCREEN_W)-1:0] pix_x,
    output logic [$clog2(SCREEN_H)-1:0] pix_y,
    output logic                        pix_valid,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        underflow_err
);

    localparam int XW = $clog2(SCREEN_W);
    localparam int YW = $clog2(SCREEN_H);
    localparam int CW = $clog2(TAG_SIZE + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [XW-1:0]    X_LAST   = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0]    Y_LAST   = YW'(SCREEN_H - 1);
    localparam logic [CW-1:0]    CRED_MAX = CW'(TAG_SIZE);
    localparam logic [WIDTH-1:0] HALF_W   = WIDTH'(SCREEN_W / 2);
    localparam logic [WIDTH-1:0] HALF_H   = WIDTH'(SCREEN_H / 2);
    localparam logic [WIDTH-1:0] DIR_Z    = WIDTH'(0) - (WIDTH'(FOCAL) << Q_BITS);

    logic [1:0]       state_q, state_d;
    logic [XW-1:0]    px_q, px_d;
    logic [YW-1:0]    py_q, py_d;
    logic             last_q, last_d;
    logic [CW-1:0]    credits_q, credits_d;
    logic             norm_start_q, norm_start_d;
    RayDirection      dir_q, dir_d;
    logic             frame_done_q, frame_done_d;
    logic             busy_q, busy_d;
    logic             underflow_err_q, underflow_err_d;

    logic             fifo_empty_s;
    logic             ret_s;
    logic             issue_s;
    logic [CW-1:0]    avail_s;
    logic [WIDTH-1:0] dx_s, dy_s;
    logic [XW-1:0]    push_x_s;
    logic [YW-1:0]    push_y_s;

    // A result only returns a credit if it matches a ray actually in flight.
    assign ret_s   = norm_valid & ~fifo_empty_s;
    assign avail_s = credits_q + CW'(ret_s);

    // Frame sequencing, issue decision and credit accounting.
    always_comb begin
        state_d         = state_q;
        px_d            = px_q;
        py_d            = py_q;
        last_d          = last_q;
        dir_d           = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_ISSUE;
                    px_d    = {XW{1'b0}};
                    py_d    = {YW{1'b0}};
                    last_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (last_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (avail_s == CRED_MAX) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The issue is decided one edge ahead so norm_start and dir come out registered.
        issue_s  = (state_d == ST_ISSUE) && !last_d && (avail_s != {CW{1'b0}});
        push_x_s = px_d;
        push_y_s = py_d;
        dx_s     = (WIDTH'(px_d) - HALF_W) << Q_BITS;
        dy_s     = (HALF_H - WIDTH'(py_d)) << Q_BITS;
        if (issue_s) begin
            dir_d.x = DIR_W'($signed(dx_s));
            dir_d.y = DIR_W'($signed(dy_s));
            dir_d.z = DIR_W'($signed(DIR_Z));
            if (px_d == X_LAST) begin
                px_d = {XW{1'b0}};
                if (py_d == Y_LAST) begin
                    last_d = 1'b1;
                end else begin
                    py_d = py_d + YW'(1);
                end
            end else begin
                px_d = px_d + XW'(1);
            end
        end else begin
            dir_d = dir_q;
        end

        credits_d       = avail_s - CW'(issue_s);
        norm_start_d    = issue_s;
        frame_done_d    = (state_d == ST_DONE);
        busy_d          = (state_d != ST_IDLE);
        underflow_err_d = underflow_err_q | (norm_valid & fifo_empty_s);
    end

    // Registered state and outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            px_q            <= {XW{1'b0}};
            py_q            <= {YW{1'b0}};
            last_q          <= 1'b0;
            credits_q       <= CRED_MAX;
            norm_start_q    <= 1'b0;
            dir_q           <= {(3 * DIR_W){1'b0}};
            frame_done_q    <= 1'b0;
            busy_q          <= 1'b0;
            underflow_err_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            px_q            <= px_d;
            py_q            <= py_d;
            last_q          <= last_d;
            credits_q       <= credits_d;
            norm_start_q    <= norm_start_d;
            dir_q           <= dir_d;
            frame_done_q    <= frame_done_d;
            busy_q          <= busy_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    coord_fifo #(
        .DEPTH (TAG_SIZE),
        .X_W   (XW),
        .Y_W   (YW)
    ) u_coord_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (issue_s),
        .push_x (push_x_s),
        .push_y (push_y_s),
        .pop    (ret_s),
        .head_x (pix_x),
        .head_y (pix_y),
        .empty  (fifo_empty_s)
    );

    assign norm_start    = norm_start_q;
    assign dir           = dir_q;
    assign pix_valid     = ret_s;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_ray_dir_gen.sv
// Scoreboard bench for ray_dir_gen on a 4x2 screen with 4 credits; expected
// pixels are queued at issue and matched against labelled results.
module tb_ray_dir_gen;
    import ray_dir_gen_pkg::*;

    localparam int SW = 4;
    localparam int SH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        norm_start;
    RayDirection dir;
    logic        norm_valid;
    logic [1:0]  pix_x;
    logic [0:0]  pix_y;
    logic        pix_valid;
    logic        busy;
    logic        frame_done;
    logic        underflow_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_issue, n_pix, n_done, done_cyc, last_pix_cyc, ex, ey;
    int q_x[$];
    int q_y[$];
    logic [4:0] dl;
    logic loop_en, nv_man, fs_man, rst_man, nv;

    ray_dir_gen #(
        .WIDTH(32), .Q_BITS(16), .TAG_SIZE(4),
        .SCREEN_W(SW), .SCREEN_H(SH), .FOCAL(2)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .norm_start(norm_start), .dir(dir), .norm_valid(norm_valid),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .busy(busy), .frame_done(frame_done), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_dx(input int px);
        int v;
        v = (px - SW / 2) * 65536;
        return 32'(v);
    endfunction

    function automatic logic [31:0] exp_dy(input int py);
        int v;
        v = (SH / 2 - py) * 65536;
        return 32'(v);
    endfunction

    task automatic reset_model();
        q_x.delete();
        q_y.delete();
        dl = 5'd0;
        ex = 0; ey = 0;
        n_issue = 0; n_pix = 0; n_done = 0;
        done_cyc = 0; last_pix_cyc = 0;
    endtask

    // One clock: sample registered outputs mid-cycle, drive inputs, check results.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (norm_start === 1'b1) begin
            n_issue++;
            check_eq("dir_x", dir.x, exp_dx(ex));
            check_eq("dir_y", dir.y, exp_dy(ey));
            check_eq("dir_z", dir.z, 32'hFFFE0000);
            q_x.push_back(ex);
            q_y.push_back(ey);
            ex++;
            if (ex == SW) begin
                ex = 0;
                ey++;
            end
        end
        if (frame_done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
        nv = loop_en ? dl[4] : nv_man;
        dl = {dl[3:0], norm_start};
        norm_valid  = nv;
        frame_start = fs_man;
        reset       = rst_man;
        #1;
        if (nv && q_x.size() > 0 && !rst_man) begin
            check_eq("pix_valid", pix_valid, 1'b1);
            check_eq("pix_x", pix_x, q_x.pop_front());
            check_eq("pix_y", pix_y, q_y.pop_front());
            n_pix++;
            last_pix_cyc = cyc;
        end else if (pix_valid === 1'b1 && !rst_man) begin
            check_eq("pix_spurious", pix_valid, 1'b0);
        end
    endtask

    task automatic check_reset_outs();
        check_eq("rst_norm_start", norm_start, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_frame_done", frame_done, 1'b0);
        check_eq("rst_underflow", underflow_err, 1'b0);
        check_eq("rst_pix_valid", pix_valid, 1'b0);
        check_eq("rst_dir_x", dir.x, 32'h0);
        check_eq("rst_dir_y", dir.y, 32'h0);
        check_eq("rst_dir_z", dir.z, 32'h0);
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; norm_valid = 1'b0;
        rst_man = 1'b1; fs_man = 1'b0; nv_man = 1'b0; loop_en = 1'b0;
        reset_model();
        repeat (3) tick();
        check_reset_outs();
        rst_man = 1'b0;
        reset_model();
        tick();

        // Credit stall: normalizer never answers.
        fs_man = 1'b1; tick(); fs_man = 1'b0;
        tick();
        check_eq("lat_norm_start", norm_start, 1'b1);
        check_eq("first_dir_x", dir.x, 32'hFFFE0000);
        check_eq("first_dir_y", dir.y, 32'h00010000);
        check_eq("first_dir_z", dir.z, 32'hFFFE0000);
        repeat (9) tick();
        check_eq("stall_issues", n_issue, 4);
        check_eq("stall_busy", busy, 1'b1);
        nv_man = 1'b1; tick(); nv_man = 1'b0;
        tick();
        check_eq("iss5_norm_start", norm_start, 1'b1);
        check_eq("iss5_count", n_issue, 5);
        repeat (4) tick();
        check_eq("stall2_issues", n_issue, 5);
        rst_man = 1'b1; repeat (2) tick();
        check_reset_outs();
        rst_man = 1'b0;
        reset_model();

        // Reset after the third issue abandons the frame.
        fs_man = 1'b1; tick(); fs_man = 1'b0;
        for (int i = 0; i < 20 && n_issue < 3; i++) tick();
        check_eq("mid_issues", n_issue, 3);
        rst_man = 1'b1; repeat (2) tick();
        check_reset_outs();
        rst_man = 1'b0;
        reset_model();
        repeat (3) tick();
        check_eq("mid_no_done", n_done, 0);

        // Full frame through a 5-cycle loopback normalizer.
        loop_en = 1'b1;
        fs_man = 1'b1; tick(); fs_man = 1'b0;
        tick();
        check_eq("restart_norm_start", norm_start, 1'b1);
        check_eq("restart_dir_x", dir.x, 32'hFFFE0000);
        for (int i = 0; i < 200 && n_done == 0; i++) tick();
        check_eq("frame_done_seen", n_done, 1);
        check_eq("frame_issues", n_issue, 8);
        check_eq("frame_pixels", n_pix, 8);
        check_eq("done_latency", 64'(done_cyc - last_pix_cyc), 64'd1);
        check_eq("queue_drained", q_x.size(), 0);
        repeat (3) tick();
        check_eq("done_once", n_done, 1);
        check_eq("idle_busy", busy, 1'b0);
        loop_en = 1'b0;

        // Result with nothing in flight.
        nv_man = 1'b1; tick();
        check_eq("uf_pix_valid", pix_valid, 1'b0);
        nv_man = 1'b0;
        tick();
        check_eq("uf_set", underflow_err, 1'b1);
        repeat (5) tick();
        check_eq("uf_sticky", underflow_err, 1'b1);
        check_eq("uf_busy", busy, 1'b0);
        rst_man = 1'b1; repeat (2) tick();
        check_eq("uf_cleared", underflow_err, 1'b0);
        rst_man = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
